// File: rtl/led_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// led_ctrl_pkg
//   Shared types and constants for the 4-LED pattern sequencer.
//   - led_mode_e   : pattern mode (FLOW_L, FLOW_R, BLINK, BOUNCE)
//   - PAT_*        : pattern loaded when a mode is entered
//   - SPEED_W      : width of the speed level
//   - CNT_MAX_DEF  : default base-tick prescaler terminal count (25 ms @ 50 MHz)
//   - DIV_MAX_DEF  : default base ticks per step at speed 0
//   - mode_init()  : initial pattern of a mode
//   - is_onehot()  : pattern legality check for the shifting modes
// ----------------------------------------------------------------------------
package led_ctrl_pkg;

    typedef enum logic [1:0] {
        FLOW_L = 2'd0,
        FLOW_R = 2'd1,
        BLINK  = 2'd2,
        BOUNCE = 2'd3
    } led_mode_e;

    localparam int          SPEED_W     = 2;
    localparam int          LED_W       = 4;
    localparam logic [24:0] CNT_MAX_DEF = 25'd1_249_999;
    localparam logic [3:0]  DIV_MAX_DEF = 4'd8;

    localparam logic [LED_W-1:0] PAT_FLOW_L = 4'b0001;
    localparam logic [LED_W-1:0] PAT_FLOW_R = 4'b1000;
    localparam logic [LED_W-1:0] PAT_BLINK  = 4'b1111;
    localparam logic [LED_W-1:0] PAT_BOUNCE = 4'b0001;

    function automatic logic [LED_W-1:0] mode_init(input led_mode_e mode);
        logic [LED_W-1:0] pat;
        case (mode)
            FLOW_L:  pat = PAT_FLOW_L;
            FLOW_R:  pat = PAT_FLOW_R;
            BLINK:   pat = PAT_BLINK;
            BOUNCE:  pat = PAT_BOUNCE;
            default: pat = PAT_FLOW_L;
        endcase
        return pat;
    endfunction

    function automatic logic is_onehot(input logic [LED_W-1:0] pat);
        return (pat != 4'd0) && ((pat & (pat - 4'd1)) == 4'd0);
    endfunction

endpackage

// File: rtl/led_tick_gen.sv
// ----------------------------------------------------------------------------
// led_tick_gen
//   Step timebase: a free-running prescaler produces a base tick every
//   CNT_MAX+1 clocks; a divider counts base ticks and strobes step_o every
//   (DIV_MAX >> speed) ticks (8/4/2/1 at speeds 0..3 with DIV_MAX = 8).
// Ports
//   sys_clk    in   system clock
//   sys_rst_n  in   asynchronous active-low reset
//   speed_i    in   speed level 0..3
//   clr_i      in   clears both counters and masks the strobe this cycle
//   step_o     out  combinational 1-cycle step strobe
// ----------------------------------------------------------------------------
module led_tick_gen
    import led_ctrl_pkg::*;
#(
    parameter logic [24:0] CNT_MAX = CNT_MAX_DEF,
    parameter logic [3:0]  DIV_MAX = DIV_MAX_DEF
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic [SPEED_W-1:0] speed_i,
    input  logic               clr_i,
    output logic               step_o
);

    logic [24:0] cnt_q;
    logic [3:0]  div_cnt_q;
    logic        base_tick;
    logic [3:0]  div_last;

    assign base_tick = (cnt_q == CNT_MAX);
    // DIV_MAX is a power of two, so the shift gives 8,4,2,1 ticks per step.
    assign div_last  = (DIV_MAX >> speed_i) - 4'd1;
    // A key press in the same cycle wins over the step.
    assign step_o    = base_tick && (div_cnt_q == div_last) && !clr_i;

    // NOTE: non-blocking assignments for all state, so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_q     <= '0;
            div_cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q     <= '0;
            div_cnt_q <= '0;
        end else begin
            cnt_q <= base_tick ? 25'd0 : cnt_q + 25'd1;
            if (base_tick) begin
                div_cnt_q <= (div_cnt_q == div_last) ? 4'd0 : div_cnt_q + 4'd1;
            end
        end
    end

endmodule

// File: rtl/led_pattern_ctrl.sv
// ----------------------------------------------------------------------------
// led_pattern_ctrl
//   Sequencer for the 4-LED bank. Key pulses select the pattern mode and the
//   step speed; led_tick_gen paces the steps; the pattern drives active-low
//   LED pins from a register so the pins never see combinational glitches.
// Ports
//   sys_clk    in   1  system clock
//   sys_rst_n  in   1  asynchronous active-low reset
//   key_mode   in   1  1-cycle pulse: advance mode (wraps 3 -> 0)
//   key_speed  in   1  1-cycle pulse: advance speed level (wraps 3 -> 0)
//   duty       in   4  PWM brightness (only with LED_PWM_DIM_EN)
//   led_out    out  4  LED pins, active-low (0 = lit)
//   mode_out   out  2  current mode
//   speed_out  out  2  current speed level
//   step_out   out  1  1-cycle pulse, coincident with the new pattern
// Configuration
//   LED_PWM_DIM_EN : adds the duty port and a free-running 4-bit PWM counter;
//                    an LED is lit only while pwm_cnt < duty.
// ----------------------------------------------------------------------------
module led_pattern_ctrl
    import led_ctrl_pkg::*;
#(
    parameter logic [24:0] CNT_MAX = CNT_MAX_DEF,
    parameter logic [3:0]  DIV_MAX = DIV_MAX_DEF
) (
    input  logic         sys_clk,
    input  logic         sys_rst_n,
    input  logic         key_mode,
    input  logic         key_speed,
`ifdef LED_PWM_DIM_EN
    input  logic [3:0]   duty,
`endif
    output logic [3:0]   led_out,
    output logic [1:0]   mode_out,
    output logic [1:0]   speed_out,
    output logic         step_out
);

    led_mode_e          mode_q, mode_d;
    logic [SPEED_W-1:0] speed_q, speed_d;
    logic [LED_W-1:0]   pattern_q, pattern_d;
    logic               dir_up_q, dir_up_d;
    logic               step_q;
    logic [LED_W-1:0]   led_q, led_d;
    logic               step_w;
    logic               key_any;

    assign key_any = key_mode | key_speed;

    led_tick_gen #(
        .CNT_MAX (CNT_MAX),
        .DIV_MAX (DIV_MAX)
    ) u_tick_gen (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .speed_i   (speed_q),
        .clr_i     (key_any),
        .step_o    (step_w)
    );

`ifdef LED_PWM_DIM_EN
    logic [3:0] pwm_cnt_q;
`endif

    // NOTE: every variable gets a default first so no path leaves one
    // unassigned, which would infer a latch.
    always_comb begin
        mode_d    = mode_q;
        speed_d   = speed_q;
        pattern_d = pattern_q;
        dir_up_d  = dir_up_q;

        if (key_speed) begin
            speed_d = speed_q + 2'd1;
        end

        if (key_mode) begin
            mode_d    = led_mode_e'(mode_q + 2'd1);
            pattern_d = mode_init(mode_d);
            dir_up_d  = 1'b1;
        end else if (step_w) begin
            // A corrupted pattern restarts the mode on the next step.
            case (mode_q)
                FLOW_L: begin
                    pattern_d = is_onehot(pattern_q) ? {pattern_q[2:0], pattern_q[3]}
                                                     : PAT_FLOW_L;
                end
                FLOW_R: begin
                    pattern_d = is_onehot(pattern_q) ? {pattern_q[0], pattern_q[3:1]}
                                                     : PAT_FLOW_R;
                end
                BLINK: begin
                    // 1111 -> 0000; 0000 and anything illegal -> 1111.
                    pattern_d = (pattern_q == 4'b1111) ? 4'b0000 : PAT_BLINK;
                end
                BOUNCE: begin
                    if (!is_onehot(pattern_q)) begin
                        pattern_d = PAT_BOUNCE;
                        dir_up_d  = 1'b1;
                    end else if (dir_up_q) begin
                        if (pattern_q[3]) begin
                            pattern_d = 4'b0100;
                            dir_up_d  = 1'b0;
                        end else begin
                            pattern_d = pattern_q << 1;
                        end
                    end else begin
                        if (pattern_q[0]) begin
                            pattern_d = 4'b0010;
                            dir_up_d  = 1'b1;
                        end else begin
                            pattern_d = pattern_q >> 1;
                        end
                    end
                end
                default: pattern_d = PAT_FLOW_L;
            endcase
        end

`ifdef LED_PWM_DIM_EN
        led_d = ~(pattern_d & {LED_W{pwm_cnt_q < duty}});
`else
        led_d = ~pattern_d;
`endif
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            mode_q    <= FLOW_L;
            speed_q   <= '0;
            pattern_q <= PAT_FLOW_L;
            dir_up_q  <= 1'b1;
            step_q    <= 1'b0;
            led_q     <= ~PAT_FLOW_L;
        end else begin
            mode_q    <= mode_d;
            speed_q   <= speed_d;
            pattern_q <= pattern_d;
            dir_up_q  <= dir_up_d;
            step_q    <= step_w;
            led_q     <= led_d;
        end
    end

`ifdef LED_PWM_DIM_EN
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pwm_cnt_q <= '0;
        end else begin
            pwm_cnt_q <= pwm_cnt_q + 4'd1;
        end
    end
`endif

    assign led_out   = led_q;
    assign mode_out  = mode_q;
    assign speed_out = speed_q;
    assign step_out  = step_q;

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// ----------------------------------------------------------------------------
// tb_led_pattern_ctrl
//   Directed bench for led_pattern_ctrl with CNT_MAX = 3, DIV_MAX = 8
//   (one base tick every 4 clocks, 32 clocks per step at speed 0).
//   Expected LED/mode/speed triples are queued when a step is anticipated
//   and popped when step_out fires; step latency is checked alongside.
// ----------------------------------------------------------------------------
module tb_led_pattern_ctrl;

    typedef struct packed {
        logic [3:0] led;
        logic [1:0] mode;
        logic [1:0] speed;
    } exp_t;

    logic       sys_clk;
    logic       sys_rst_n;
    logic       key_mode;
    logic       key_speed;
`ifdef LED_PWM_DIM_EN
    logic [3:0] duty;
`endif
    logic [3:0] led_out;
    logic [1:0] mode_out;
    logic [1:0] speed_out;
    logic       step_out;

    exp_t sb_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    led_pattern_ctrl #(
        .CNT_MAX (25'd3),
        .DIV_MAX (4'd8)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .key_mode  (key_mode),
        .key_speed (key_speed),
`ifdef LED_PWM_DIM_EN
        .duty      (duty),
`endif
        .led_out   (led_out),
        .mode_out  (mode_out),
        .speed_out (speed_out),
        .step_out  (step_out)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no end of test, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Check the state right after an edge: LED pins, mode, speed, step strobe.
    task automatic check_state(input string tag, input logic [3:0] led,
                               input logic [1:0] mode, input logic [1:0] speed,
                               input logic step);
        check({tag, "/led"},   {12'd0, led_out},   {12'd0, led});
        check({tag, "/mode"},  {14'd0, mode_out},  {14'd0, mode});
        check({tag, "/speed"}, {14'd0, speed_out}, {14'd0, speed});
        check({tag, "/step"},  {15'd0, step_out},  {15'd0, step});
    endtask

    task automatic key_pulse(input logic m, input logic s);
        key_mode  = m;
        key_speed = s;
        @(posedge sys_clk);
        #1;
        key_mode  = 1'b0;
        key_speed = 1'b0;
    endtask

    // Queue the expected result, then wait (bounded) for step_out and compare.
    task automatic expect_step(input string tag, input logic [3:0] led,
                               input logic [1:0] mode, input logic [1:0] speed,
                               input int cycles);
        exp_t e;
        int   n;
        bit   got;
        sb_q.push_back('{led: led, mode: mode, speed: speed});
        n   = 0;
        got = 1'b0;
        while (n < 200 && !got) begin
            @(posedge sys_clk);
            #1;
            n++;
            if (step_out === 1'b1) got = 1'b1;
        end
        check({tag, "/latency"}, n[15:0], cycles[15:0]);
        e = sb_q.pop_front();
        check({tag, "/out"}, {8'd0, led_out, mode_out, speed_out},
              {8'd0, e.led, e.mode, e.speed});
    endtask

    initial begin
        key_mode  = 1'b0;
        key_speed = 1'b0;
        sys_rst_n = 1'b0;
`ifdef LED_PWM_DIM_EN
        duty      = 4'd0;
`endif
        repeat (3) @(posedge sys_clk);
        #1;
        check_state("reset", 4'b1110, 2'd0, 2'd0, 1'b0);
        sys_rst_n = 1'b1;

`ifdef LED_PWM_DIM_EN
        begin
            int lit;
            lit = 0;
            for (int i = 0; i < 16; i++) begin
                @(posedge sys_clk);
                #1;
                if (led_out != 4'b1111) lit++;
            end
            check("pwm_duty0_dark", lit[15:0], 16'd0);
            duty = 4'd4;
            @(posedge sys_clk);
            #1;
            lit = 0;
            for (int i = 0; i < 16; i++) begin
                @(posedge sys_clk);
                #1;
                if (led_out != 4'b1111) lit++;
            end
            check("pwm_duty4_lit", lit[15:0], 16'd4);
        end
`else
        // FLOW_L: four steps wrap back to the start.
        expect_step("flow_l_1", 4'b1101, 2'd0, 2'd0, 32);
        expect_step("flow_l_2", 4'b1011, 2'd0, 2'd0, 32);
        expect_step("flow_l_3", 4'b0111, 2'd0, 2'd0, 32);
        expect_step("flow_l_4", 4'b1110, 2'd0, 2'd0, 32);

        // FLOW_R
        key_pulse(1'b1, 1'b0);
        check_state("key_flow_r", 4'b0111, 2'd1, 2'd0, 1'b0);
        expect_step("flow_r_1", 4'b1011, 2'd1, 2'd0, 32);

        // BLINK
        key_pulse(1'b1, 1'b0);
        check_state("key_blink", 4'b0000, 2'd2, 2'd0, 1'b0);
        expect_step("blink_1", 4'b1111, 2'd2, 2'd0, 32);

        // BOUNCE: direction flips at both ends.
        key_pulse(1'b1, 1'b0);
        check_state("key_bounce", 4'b1110, 2'd3, 2'd0, 1'b0);
        expect_step("bounce_1", 4'b1101, 2'd3, 2'd0, 32);
        expect_step("bounce_2", 4'b1011, 2'd3, 2'd0, 32);
        expect_step("bounce_3", 4'b0111, 2'd3, 2'd0, 32);
        expect_step("bounce_4", 4'b1011, 2'd3, 2'd0, 32);
        expect_step("bounce_5", 4'b1101, 2'd3, 2'd0, 32);
        expect_step("bounce_6", 4'b1110, 2'd3, 2'd0, 32);
        expect_step("bounce_7", 4'b1101, 2'd3, 2'd0, 32);

        // Speed levels 1..3, then wrap to 0.
        key_pulse(1'b0, 1'b1);
        check_state("key_speed1", 4'b1101, 2'd3, 2'd1, 1'b0);
        expect_step("speed1", 4'b1011, 2'd3, 2'd1, 16);
        key_pulse(1'b0, 1'b1);
        expect_step("speed2", 4'b0111, 2'd3, 2'd2, 8);
        key_pulse(1'b0, 1'b1);
        expect_step("speed3_a", 4'b1011, 2'd3, 2'd3, 4);
        expect_step("speed3_b", 4'b1101, 2'd3, 2'd3, 4);
        key_pulse(1'b0, 1'b1);
        check_state("key_speed_wrap", 4'b1101, 2'd3, 2'd0, 1'b0);
        expect_step("speed0_a", 4'b1110, 2'd3, 2'd0, 32);
        expect_step("speed0_b", 4'b1101, 2'd3, 2'd0, 32);

        // key_mode lands exactly on the step cycle: mode wraps to FLOW_L.
        repeat (31) @(posedge sys_clk);
        #1;
        key_pulse(1'b1, 1'b0);
        check_state("mode_on_step", 4'b1110, 2'd0, 2'd0, 1'b0);
        expect_step("after_mode_on_step", 4'b1101, 2'd0, 2'd0, 32);

        // key_speed on the step cycle: pattern kept, no step.
        repeat (31) @(posedge sys_clk);
        #1;
        key_pulse(1'b0, 1'b1);
        check_state("speed_on_step", 4'b1101, 2'd0, 2'd1, 1'b0);
        expect_step("after_speed_on_step", 4'b1011, 2'd0, 2'd1, 16);

        // Both keys together: both applied.
        key_pulse(1'b1, 1'b1);
        check_state("both_keys", 4'b0111, 2'd1, 2'd2, 1'b0);
        expect_step("after_both_keys", 4'b1011, 2'd1, 2'd2, 8);

        // Asynchronous reset mid-sequence.
        repeat (3) @(posedge sys_clk);
        #3;
        sys_rst_n = 1'b0;
        #1;
        check_state("async_reset", 4'b1110, 2'd0, 2'd0, 1'b0);
        @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b1;
        expect_step("post_reset", 4'b1101, 2'd0, 2'd0, 32);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
